// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: 7-bit-address I2C target with oversampled SDA/SCL, START/STOP detection and fabric byte handshake.
// Define I2C_SLAVE_CLOCK_STRETCH_EN to hold SCL low while the fabric is not ready instead of NACKing.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h42,
  parameter int         SDA_HOLD_CLKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       rx_ready,
  input  logic [7:0] data_in,
  output logic       data_request,
  input  logic       tx_valid,
  output logic       master_nack_received,
  output logic       communication_ongoing
);

  // state        | meaning
  // S_IDLE       | bus free or not yet addressed
  // S_ADDR       | shifting {addr, R/W}
  // S_ADDR_ACK   | address matched, ACK driven on 9th clock
  // S_RX_BYTE    | receiving a write byte
  // S_RX_ACK     | ACK/NACK of a write byte
  // S_RX_STRETCH | SCL held low until fabric accepts the byte
  // S_TX_BYTE    | shifting a read byte out
  // S_TX_ACK     | sampling the master's ACK/NACK
  // S_TX_STRETCH | SCL held low until fabric offers a byte
  // S_IGNORE     | not addressed or master NACKed; wait for START/STOP
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_RX_STRETCH,
    S_TX_BYTE, S_TX_ACK, S_TX_STRETCH, S_IGNORE
  } state_t;

  localparam int HCW = (SDA_HOLD_CLKS > 1) ? $clog2(SDA_HOLD_CLKS) : 1;

  state_t         r_state, w_state_nx;
  logic [1:0]     r_sda_sync, r_scl_sync;
  logic           r_sda_prev, r_scl_prev;
  logic [7:0]     r_shift, r_tx, r_data_out;
  logic [2:0]     r_bit_cnt;
  logic           r_rw, r_rx_ack;
  logic           r_data_valid, r_data_request, r_nack, r_ongoing;
  logic           r_sda_low, r_scl_low, r_sda_pend, r_hold_act;
  logic [HCW-1:0] r_hold_cnt;

  logic       w_sda, w_scl, w_start, w_stop, w_scl_rise, w_scl_fall;
  logic [7:0] w_rx_byte, w_deliver_byte;
  logic       w_rel_now, w_sched, w_sched_low, w_sda_now;
  logic       w_shift, w_cnt_rst, w_cnt_dec, w_match, w_deliver, w_ack_load;
  logic       w_req, w_nack, w_tx_load, w_stretch_on;

  assign w_sda      = r_sda_sync[1];
  assign w_scl      = r_scl_sync[1];
  assign w_start    = r_sda_prev & ~w_sda & w_scl;
  assign w_stop     = ~r_sda_prev & w_sda & w_scl;
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_rx_byte  = {r_shift[6:0], w_sda};

  assign i2c_sda = r_sda_low ? 1'b0 : 1'bz;
  assign i2c_scl = r_scl_low ? 1'b0 : 1'bz;

  assign data_out              = r_data_out;
  assign data_valid            = r_data_valid;
  assign data_request          = r_data_request;
  assign master_nack_received  = r_nack;
  assign communication_ongoing = r_ongoing;

`ifndef I2C_SLAVE_CLOCK_STRETCH_EN
  logic w_unused_tx_valid;
  assign w_unused_tx_valid = tx_valid;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_rel_now      = 1'b0;
    w_sched        = 1'b0;
    w_sched_low    = 1'b0;
    w_sda_now      = 1'b0;
    w_shift        = 1'b0;
    w_cnt_rst      = 1'b0;
    w_cnt_dec      = 1'b0;
    w_match        = 1'b0;
    w_deliver      = 1'b0;
    w_deliver_byte = 8'h00;
    w_ack_load     = 1'b0;
    w_req          = 1'b0;
    w_nack         = 1'b0;
    w_tx_load      = 1'b0;
    w_stretch_on   = 1'b0;
    if (w_stop) begin
      w_state_nx = S_IDLE;
      w_rel_now  = 1'b1;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
      w_rel_now  = 1'b1;
      w_cnt_rst  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift = 1'b1;
            if (r_bit_cnt == 3'd0) begin
              w_cnt_rst = 1'b1;
              if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                w_match    = 1'b1;
                w_state_nx = S_ADDR_ACK;
              end else begin
                w_state_nx = S_IGNORE;
              end
            end else begin
              w_cnt_dec = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sched     = 1'b1;
            w_sched_low = 1'b1;
          end else if (w_scl_rise) begin
            w_state_nx = r_rw ? S_TX_BYTE : S_RX_BYTE;
            w_req      = r_rw;
          end
        end
        S_RX_BYTE: begin
          if (w_scl_fall) begin
            w_sched = 1'b1;
          end else if (w_scl_rise) begin
            w_shift = 1'b1;
            if (r_bit_cnt == 3'd0) begin
              w_cnt_rst      = 1'b1;
              w_ack_load     = 1'b1;
              w_state_nx     = S_RX_ACK;
              w_deliver      = rx_ready;
              w_deliver_byte = w_rx_byte;
            end else begin
              w_cnt_dec = 1'b1;
            end
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            if (!r_rx_ack) begin
              w_state_nx   = S_RX_STRETCH;
              w_stretch_on = 1'b1;
            end else begin
              w_sched     = 1'b1;
              w_sched_low = 1'b1;
            end
`else
            w_sched     = 1'b1;
            w_sched_low = r_rx_ack;
`endif
          end else if (w_scl_rise) begin
            w_state_nx = S_RX_BYTE;
          end
        end
        S_RX_STRETCH: begin
          // ACK goes out at once; the hold timer then lets SCL go
          if (rx_ready) begin
            w_deliver      = 1'b1;
            w_deliver_byte = r_shift;
            w_sched        = 1'b1;
            w_sched_low    = 1'b1;
            w_sda_now      = 1'b1;
            w_state_nx     = S_RX_ACK;
          end
        end
        S_TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
              if (!tx_valid) begin
                w_state_nx   = S_TX_STRETCH;
                w_stretch_on = 1'b1;
              end else begin
                w_tx_load   = 1'b1;
                w_sched     = 1'b1;
                w_sched_low = ~data_in[7];
              end
`else
              w_tx_load   = 1'b1;
              w_sched     = 1'b1;
              w_sched_low = ~data_in[7];
`endif
            end else begin
              w_sched     = 1'b1;
              w_sched_low = ~r_tx[r_bit_cnt];
            end
          end else if (w_scl_rise) begin
            if (r_bit_cnt == 3'd0) begin
              w_cnt_rst  = 1'b1;
              w_state_nx = S_TX_ACK;
            end else begin
              w_cnt_dec = 1'b1;
            end
          end
        end
        S_TX_STRETCH: begin
          if (tx_valid) begin
            w_tx_load   = 1'b1;
            w_sched     = 1'b1;
            w_sched_low = ~data_in[7];
            w_sda_now   = 1'b1;
            w_state_nx  = S_TX_BYTE;
          end
        end
        S_TX_ACK: begin
          if (w_scl_fall) begin
            w_sched = 1'b1;
          end else if (w_scl_rise) begin
            if (!w_sda) begin
              w_req      = 1'b1;
              w_state_nx = S_TX_BYTE;
            end else begin
              w_nack     = 1'b1;
              w_rel_now  = 1'b1;
              w_state_nx = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sda_sync     <= 2'b11;
      r_scl_sync     <= 2'b11;
      r_sda_prev     <= 1'b1;
      r_scl_prev     <= 1'b1;
      r_shift        <= 8'h00;
      r_tx           <= 8'h00;
      r_data_out     <= 8'h00;
      r_bit_cnt      <= 3'd7;
      r_rw           <= 1'b0;
      r_rx_ack       <= 1'b0;
      r_data_valid   <= 1'b0;
      r_data_request <= 1'b0;
      r_nack         <= 1'b0;
      r_ongoing      <= 1'b0;
      r_sda_low      <= 1'b0;
      r_scl_low      <= 1'b0;
      r_sda_pend     <= 1'b0;
      r_hold_act     <= 1'b0;
      r_hold_cnt     <= '0;
    end else begin
      r_sda_sync     <= {r_sda_sync[0], i2c_sda};
      r_scl_sync     <= {r_scl_sync[0], i2c_scl};
      r_sda_prev     <= w_sda;
      r_scl_prev     <= w_scl;
      r_data_valid   <= w_deliver;
      r_data_request <= w_req;
      if (w_shift)        r_shift <= w_rx_byte;
      if (w_cnt_rst)      r_bit_cnt <= 3'd7;
      else if (w_cnt_dec) r_bit_cnt <= r_bit_cnt - 3'd1;
      if (w_match) begin
        r_rw      <= w_rx_byte[0];
        r_ongoing <= 1'b1;
      end
      if (w_stop)     r_ongoing <= 1'b0;
      if (w_start)    r_nack <= 1'b0;
      if (w_nack)     r_nack <= 1'b1;
      if (w_deliver)  r_data_out <= w_deliver_byte;
      if (w_ack_load) r_rx_ack <= rx_ready;
      if (w_tx_load)  r_tx <= data_in;
      // every SDA change waits out the hold timer; a stretched SCL is freed with it
      if (w_rel_now) begin
        r_sda_low  <= 1'b0;
        r_scl_low  <= 1'b0;
        r_hold_act <= 1'b0;
      end else if (w_sched) begin
        r_sda_pend <= w_sched_low;
        r_hold_cnt <= HCW'(SDA_HOLD_CLKS - 1);
        r_hold_act <= 1'b1;
        if (w_sda_now) r_sda_low <= w_sched_low;
      end else if (r_hold_act) begin
        if (r_hold_cnt == '0) begin
          r_sda_low  <= r_sda_pend;
          r_scl_low  <= 1'b0;
          r_hold_act <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end
      if (w_stretch_on) r_scl_low <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: bit-banged I2C master, write-data scoreboard, fabric model.
module tb_i2c_slave_responder;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx_valid = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       m_scl_low = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, data_request, master_nack_received, communication_ongoing;
  wire        sda_bus, scl_bus;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int req_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  pullup (sda_bus);
  pullup (scl_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h42), .SDA_HOLD_CLKS(10)) dut (
    .clk(clk), .reset(reset), .i2c_sda(sda_bus), .i2c_scl(scl_bus),
    .data_out(data_out), .data_valid(data_valid), .rx_ready(rx_ready),
    .data_in(data_in), .data_request(data_request), .tx_valid(tx_valid),
    .master_nack_received(master_nack_received),
    .communication_ongoing(communication_ongoing)
  );

  // scoreboard for received bytes and fabric model serving read bytes
  always @(negedge clk) begin
    if (reset === 1'b1 && data_valid === 1'b1) begin
      logic [7:0] exp;
      dv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_valid_unexpected: data_out=%h, none expected", data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin
          errors++;
          $display("FAIL data_out: got %h expected %h", data_out, exp);
        end
      end
    end
    if (reset === 1'b1 && data_request === 1'b1) begin
      req_cnt++;
      if (tx_q.size() > 0) data_in = tx_q.pop_front();
    end
  end

  initial begin
    repeat (400000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic scl_release();
    int n = 0;
    m_scl_low = 1'b0;
    while (scl_bus !== 1'b1 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) begin
      errors++;
      $display("FAIL scl_release_timeout: scl=%b expected 1", scl_bus);
    end
  endtask

  task automatic do_start();
    wait_clks(5);
    m_sda_low = 1'b0;
    wait_clks(HALF);
    scl_release();
    wait_clks(HALF);
    m_sda_low = 1'b1;
    wait_clks(HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic do_stop();
    wait_clks(5);
    m_sda_low = 1'b1;
    wait_clks(HALF);
    scl_release();
    wait_clks(HALF);
    m_sda_low = 1'b0;
  endtask

  task automatic write_bit(input logic b);
    wait_clks(5);
    m_sda_low = ~b;
    wait_clks(HALF - 5);
    scl_release();
    wait_clks(HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic read_bit(output logic b);
    wait_clks(5);
    m_sda_low = 1'b0;
    wait_clks(HALF - 5);
    scl_release();
    wait_clks(HALF / 2);
    #1 b = sda_bus;
    wait_clks(HALF / 2);
    m_scl_low = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_clks(4);
    #1;
    checks++;
    if ({data_out, data_valid, data_request, master_nack_received, communication_ongoing} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000",
               {data_out, data_valid, data_request, master_nack_received, communication_ongoing});
    end
    checks++;
    if (sda_bus !== 1'b1 || scl_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_lines: sda=%b scl=%b expected 1 1", sda_bus, scl_bus);
    end
    reset = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_write();
    logic ack;
    int dv0 = dv_cnt;
    rx_ready = 1'b1;
    do_start();
    write_byte(8'h84, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b expected 0", ack); end
    exp_q.push_back(8'hA5);
    write_byte(8'hA5, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_a5_ack: got %b expected 0", ack); end
    checks++;
    if (communication_ongoing !== 1'b1) begin
      errors++; $display("FAIL write_ongoing: got %b expected 1", communication_ongoing);
    end
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_3c_ack: got %b expected 0", ack); end
    do_stop();
    wait_clks(3);
    #1;
    checks++;
    if (communication_ongoing !== 1'b0) begin
      errors++; $display("FAIL stop_ongoing: got %b expected 0 within 3 clk", communication_ongoing);
    end
    wait_clks(HALF);
    checks++;
    if (dv_cnt - dv0 != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL write_dv_count: got %0d pending %0d expected 2 pending 0", dv_cnt - dv0, exp_q.size());
    end
    checks++;
    if (data_out !== 8'h3C) begin errors++; $display("FAIL write_last_data: got %h expected 3c", data_out); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    logic [7:0] v;
    int dv0 = dv_cnt;
    do_start();
    write_byte(8'h86, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL wrong_addr_ack: got %b expected 1", ack); end
    read_byte(v);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL wrong_addr_sda_z: got %h expected ff", v); end
    read_bit(ack);
    checks++;
    if (dv_cnt != dv0 || communication_ongoing !== 1'b0) begin
      errors++; $display("FAIL wrong_addr_quiet: dv=%0d ongoing=%b expected 0 0", dv_cnt - dv0, communication_ongoing);
    end
    do_stop();
    wait_clks(HALF);
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] v;
    int r0 = req_cnt;
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h0F);
    do_start();
    write_byte(8'h85, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
    checks++;
    if (req_cnt - r0 != 1) begin errors++; $display("FAIL read_req_first: got %0d expected 1", req_cnt - r0); end
    read_byte(v);
    checks++;
    if (v !== 8'h96) begin errors++; $display("FAIL read_byte0: got %h expected 96", v); end
    write_bit(1'b0);
    read_byte(v);
    checks++;
    if (v !== 8'h0F) begin errors++; $display("FAIL read_byte1: got %h expected 0f", v); end
    write_bit(1'b1);
    wait_clks(4);
    checks++;
    if (master_nack_received !== 1'b1 || req_cnt - r0 != 2) begin
      errors++; $display("FAIL read_nack: nack=%b req=%0d expected 1 2", master_nack_received, req_cnt - r0);
    end
    do_stop();
    wait_clks(HALF);
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] v;
    int dv0 = dv_cnt;
    checks++;
    if (master_nack_received !== 1'b1) begin
      errors++; $display("FAIL nack_held_after_stop: got %b expected 1", master_nack_received);
    end
    do_start();
    checks++;
    if (master_nack_received !== 1'b0) begin
      errors++; $display("FAIL nack_clear_on_start: got %b expected 0", master_nack_received);
    end
    write_byte(8'h84, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    tx_q.push_back(8'hC3);
    do_start();
    write_byte(8'h85, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
    read_byte(v);
    checks++;
    if (v !== 8'hC3) begin errors++; $display("FAIL rs_read: got %h expected c3", v); end
    write_bit(1'b1);
    do_stop();
    wait_clks(HALF);
    checks++;
    if (dv_cnt != dv0) begin errors++; $display("FAIL rs_partial_dv: got %0d expected 0", dv_cnt - dv0); end
  endtask

  task automatic test_rx_not_ready();
    logic ack;
    int dv0 = dv_cnt;
    rx_ready = 1'b1;
    do_start();
    write_byte(8'h84, ack);
    rx_ready = 1'b0;
    for (int i = 7; i >= 0; i--) write_bit(i[0] ? 1'b0 : 1'b1);
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    exp_q.push_back(8'h55);
    fork
      read_bit(ack);
      begin
        wait_clks(300);
        checks++;
        if (scl_bus !== 1'b0) begin errors++; $display("FAIL stretch_scl: got %b expected 0", scl_bus); end
        rx_ready = 1'b1;
      end
    join
    checks++;
    if (ack !== 1'b0 || data_out !== 8'h55) begin
      errors++; $display("FAIL stretch_ack: ack=%b data=%h expected 0 55", ack, data_out);
    end
`else
    read_bit(ack);
    checks++;
    if (ack !== 1'b1 || dv_cnt != dv0 || data_out !== 8'h3C) begin
      errors++; $display("FAIL not_ready_nack: ack=%b dv=%0d data=%h expected 1 0 3c", ack, dv_cnt - dv0, data_out);
    end
    rx_ready = 1'b1;
`endif
    exp_q.push_back(8'h66);
    write_byte(8'h66, ack);
    checks++;
    if (ack !== 1'b0 || data_out !== 8'h66) begin
      errors++; $display("FAIL after_not_ready: ack=%b data=%h expected 0 66", ack, data_out);
    end
    do_stop();
    wait_clks(HALF);
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    do_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'h84 >> i) & 1) == 1);
    wait_clks(5);
    m_sda_low = 1'b0;
    wait_clks(30);
    checks++;
    if (sda_bus !== 1'b0 || communication_ongoing !== 1'b1) begin
      errors++; $display("FAIL mid_ack_drive: sda=%b ongoing=%b expected 0 1", sda_bus, communication_ongoing);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (sda_bus !== 1'b1 || scl_bus !== 1'b0) begin
      errors++; $display("FAIL async_release: sda=%b scl=%b expected 1 0", sda_bus, scl_bus);
    end
    checks++;
    if ({data_out, data_valid, data_request, master_nack_received, communication_ongoing} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 000",
                         {data_out, data_valid, data_request, master_nack_received, communication_ongoing});
    end
    wait_clks(3);
    reset = 1'b1;
    scl_release();
    wait_clks(HALF);
    exp_q.push_back(8'h11);
    do_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    checks++;
    if (ack !== 1'b0 || data_out !== 8'h11) begin
      errors++; $display("FAIL recover_write: ack=%b data=%h expected 0 11", ack, data_out);
    end
    do_stop();
    wait_clks(HALF);
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_rx_not_ready();
    test_reset_mid_ack();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (slave) for the same bus our i2c_controller masters: open-drain SDA/SCL, 7-bit addressing, standard/fast mode.
- Oversamples the bus on the system clock and detects START, repeated START and STOP.
- Matches its address, receives write bytes into the fabric, and serves read bytes from the fabric.
- Sits beside on-chip register blocks that must be reachable from an external or loopback master.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit address this block responds to
SDA_HOLD_CLKS, 10, sys clocks after a synchronised SCL fall before the block changes its SDA drive; must be ≥1 and below the SCL low time

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; 0 resets the block
i2c_sda  inout  1  open-drain; the block drives 0 or Z
i2c_scl  inout  1  open-drain; driven 0 only while stretching (optional feature), otherwise Z
data_out  output  8  last received write byte
data_valid  output  1  one-cycle pulse when data_out updates
rx_ready  input  1  fabric can accept a byte; sampled at the ACK decision
data_in  input  8  byte to transmit on a read
data_request  output  1  one-cycle pulse: fabric must present the next data_in
tx_valid  input  1  data_in valid; used only with the optional feature
master_nack_received  output  1  set when the master NACKs a read byte; cleared on the next START
communication_ongoing  output  1  high from an address match until STOP or reset

Behaviour:
- Reset values (reset=0, immediate): SDA and SCL released (Z), state IDLE, data_out=0, data_valid=0, data_request=0, master_nack_received=0, communication_ongoing=0, bit counter=7.
- Synchronisation: SDA and SCL each pass through 2 flops; edges are taken from the synced values, so bus-to-detect latency is 3 clk.
- START: synced SDA falls while synced SCL is high. It is honoured in every state, including mid-byte (repeated START), and moves to ADDR with bit counter 7.
- STOP: synced SDA rises while synced SCL is high. It is honoured in every state: SDA/SCL released, return to IDLE, communication_ongoing=0.
- Sampling: SDA is sampled on the synced SCL rising edge, MSB first.
- SDA drive: every change is applied SDA_HOLD_CLKS clocks after a synced SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits {addr, R/W}. Match → ADDR_ACK. Mismatch → IGNORE.
  - IGNORE: lines released; leave only on START or STOP.
  - ADDR_ACK: drive SDA=0 for the 9th clock; set communication_ongoing. W → RX_BYTE. R → TX_BYTE, with data_request pulsed at the 9th SCL rise.
  - RX_BYTE: shift 8 bits. After the 8th SCL rise, data_out is updated and data_valid pulses, unless the ACK decision is NACK.
  - RX_ACK: ACK (SDA=0) if rx_ready=1 at the 8th SCL rise. Otherwise NACK (SDA=Z), data_out is left unchanged and no data_valid pulse is issued. Then → RX_BYTE.
  - TX_BYTE: data_in is latched at the SCL fall that ends the preceding ACK. Drive bit 7..0 after each SCL fall, SDA=Z for a 1 bit. Release SDA after bit 0.
  - TX_ACK: sample the master's bit at the SCL rise.
    - 0 → pulse data_request, then TX_BYTE.
    - 1 → master_nack_received=1, lines released, IGNORE until STOP/START.
- Bit counter wraps 0→7 at each byte boundary.
- Simultaneous events: START/STOP take priority over any bit or ACK processing in the same cycle.
- Reset mid-transfer releases both lines within the same cycle (asynchronous).

Optional Feature:
- Macro I2C_SLAVE_CLOCK_STRETCH_EN.
- With it:
  - TX: at the SCL fall before the first bit of a read byte, if tx_valid=0 the block holds SCL low (drives 0) until tx_valid=1. It then latches data_in, drives bit 7, waits SDA_HOLD_CLKS and releases SCL.
  - RX: if rx_ready=0 at the ACK decision, SCL is held low after the 8th bit until rx_ready=1, and the byte is then ACKed and delivered rather than NACKed.
- Without it: the SCL output is constantly Z, tx_valid is ignored, and the NACK-on-not-ready behaviour applies.

Test Plan:
- Reset released, master writes addr 0x42 W + 0xA5, 0x3C then STOP, rx_ready=1 → both ACKs low; data_valid pulses twice with data_out 0xA5 then 0x3C; communication_ongoing falls within 3 clk of the STOP.
- Master addresses 0x43 → 9th bit NACK (SDA high); no data_valid; SDA stays Z until the next START.
- Read at 0x42 with data_in 0x96 then 0x0F, master ACKs then NACKs → bus carries 0x96, 0x0F; data_request pulses twice; master_nack_received=1.
- Repeated START after 4 bits of a write byte, then a read → partial byte discarded, no data_valid, read is served correctly.
- rx_ready=0 during a write byte 0x55 → NACK, no data_valid. With I2C_SLAVE_CLOCK_STRETCH_EN: SCL held low until rx_ready rises, then ACK and data_out=0x55.
- reset asserted mid-ACK while driving SDA=0 → SDA Z on the same edge; outputs at reset values.
